// File: rtl/l2_arbiter_pkg.sv
// Shared types for the L2 arbiter: bus widths, FSM state, requester id and grant helper.
package l2_arbiter_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned LINE_W = 128;

    typedef logic [WORD_W-1:0] lc3b_word;
    typedef logic [LINE_W-1:0] lc3b_pmem_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE   = 2'd1,
        RESPOND = 2'd2
    } lc3b_arb_state;

    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } lc3b_arb_id;

    // One requester's transaction as latched on grant; write wins when both read and write are set.
    typedef struct packed {
        logic          write;
        lc3b_word      address;
        lc3b_pmem_line wdata;
    } arb_req_t;

    // Selects the requester to grant; only meaningful when at least one is pending.
    function automatic lc3b_arb_id arb_pick(
        input logic       i_pend,
        input logic       d_pend,
        input lc3b_arb_id last,
        input logic       fair
    );
        lc3b_arb_id pick;
        pick = ARB_D;
        if (i_pend && !d_pend) begin
            pick = ARB_I;
        end else if (i_pend && d_pend && fair && (last == ARB_D)) begin
            pick = ARB_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/l2_arbiter_control.sv
// Arbiter FSM: decides grants, tracks the last grant and sequences SERVE/RESPOND.
module l2_arbiter_control
    import l2_arbiter_pkg::*;
#(
    parameter bit FAIR = 1'b1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_i_pend,
    input  logic       i_d_pend,
    input  logic       i_mem_resp,
    output logic       o_grant_c,
    output lc3b_arb_id o_grant_sel_c,
    output logic       o_capture_c,
    output lc3b_arb_id o_grant_id
);

    lc3b_arb_state r_state;
    lc3b_arb_state w_state_next;
    lc3b_arb_id    r_last_grant;
    lc3b_arb_id    w_pick;

    assign w_pick        = arb_pick(i_i_pend, i_d_pend, r_last_grant, FAIR);
    assign o_grant_sel_c = w_pick;
    assign o_grant_id    = r_last_grant;

    // State and last-grant registers; last_grant doubles as the id of the transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= ARB_I;
        end else begin
            r_state <= w_state_next;
            if (o_grant_c) begin
                r_last_grant <= w_pick;
            end
        end
    end

    // Next-state and grant/capture strobes.
    always_comb begin
        w_state_next = r_state;
        o_grant_c    = 1'b0;
        o_capture_c  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_i_pend || i_d_pend) begin
                    o_grant_c    = 1'b1;
                    w_state_next = SERVE;
                end
            end
            SERVE: begin
                if (i_mem_resp) begin
                    o_capture_c  = 1'b1;
                    w_state_next = RESPOND;
                end
            end
            RESPOND: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/l2_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter in front of the L2 upper-side memory interface.
module l2_arbiter
    import l2_arbiter_pkg::*;
#(
    parameter bit FAIR = 1'b1
)
(
    input  logic          clk,
    input  logic          reset,

    input  logic          i_read,
    input  logic          i_write,
    input  lc3b_word      i_address,
    input  lc3b_pmem_line i_wdata,
    output logic          i_resp,
    output lc3b_pmem_line i_rdata,

    input  logic          d_read,
    input  logic          d_write,
    input  lc3b_word      d_address,
    input  lc3b_pmem_line d_wdata,
    output logic          d_resp,
    output lc3b_pmem_line d_rdata,

    output logic          mem_read,
    output logic          mem_write,
    output lc3b_word      mem_address,
    output lc3b_pmem_line mem_wdata,
    input  logic          mem_resp,
    input  lc3b_pmem_line mem_rdata
);

    logic          w_grant;
    lc3b_arb_id    w_grant_sel;
    logic          w_capture;
    lc3b_arb_id    w_grant_id;
    arb_req_t      w_i_req;
    arb_req_t      w_d_req;
    arb_req_t      w_sel_req;

    arb_req_t      r_req;
    lc3b_pmem_line r_line;
    logic          r_mem_read;
    logic          r_mem_write;
    logic          r_i_resp;
    logic          r_d_resp;

    l2_arbiter_control #(
        .FAIR (FAIR)
    ) u_control (
        .clk           (clk),
        .reset         (reset),
        .i_i_pend      (i_read || i_write),
        .i_d_pend      (d_read || d_write),
        .i_mem_resp    (mem_resp),
        .o_grant_c     (w_grant),
        .o_grant_sel_c (w_grant_sel),
        .o_capture_c   (w_capture),
        .o_grant_id    (w_grant_id)
    );

    // Requester payloads; a simultaneous read+write is treated as a write.
    assign w_i_req   = '{write: i_write, address: i_address, wdata: i_wdata};
    assign w_d_req   = '{write: d_write, address: d_address, wdata: d_wdata};
    assign w_sel_req = (w_grant_sel == ARB_D) ? w_d_req : w_i_req;

    // Transaction latch, memory request strobes, response line and one-cycle resp pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req       <= '0;
            r_line      <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_i_resp    <= 1'b0;
            r_d_resp    <= 1'b0;
        end else begin
            r_i_resp <= w_capture && (w_grant_id == ARB_I);
            r_d_resp <= w_capture && (w_grant_id == ARB_D);
            if (w_grant) begin
                r_req       <= w_sel_req;
                r_mem_read  <= !w_sel_req.write;
                r_mem_write <= w_sel_req.write;
            end
            if (w_capture) begin
                r_line      <= mem_rdata;
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
            end
        end
    end

    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_address = r_req.address;
    assign mem_wdata   = r_req.wdata;
    assign i_resp      = r_i_resp;
    assign d_resp      = r_d_resp;
    assign i_rdata     = r_line;
    assign d_rdata     = r_line;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed self-checking bench for l2_arbiter: one round-robin and one fixed-priority instance on shared inputs.
module tb_l2_arbiter;

    logic         clk;
    logic         reset;
    logic         i_read, i_write, d_read, d_write;
    logic [15:0]  i_address, d_address;
    logic [127:0] i_wdata, d_wdata;
    logic         mem_resp;
    logic [127:0] mem_rdata;

    logic         i_resp, d_resp, mem_read, mem_write;
    logic [127:0] i_rdata, d_rdata, mem_wdata;
    logic [15:0]  mem_address;

    logic         f_i_resp, f_d_resp, f_mem_read, f_mem_write;
    logic [127:0] f_i_rdata, f_d_rdata, f_mem_wdata;
    logic [15:0]  f_mem_address;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [127:0] LINE_A = {8{16'hAAAA}};
    localparam logic [127:0] LINE_B = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] LINE_C = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [127:0] LINE_5 = {32{4'h5}};

    l2_arbiter #(.FAIR(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
        .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    l2_arbiter #(.FAIR(1'b0)) u_dut_fp (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
        .i_resp(f_i_resp), .i_rdata(f_i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(f_d_resp), .d_rdata(f_d_rdata),
        .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_address(f_mem_address),
        .mem_wdata(f_mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One-cycle L2 completion pulse driven from a negedge; returns at the negedge of the resp cycle.
    task automatic l2_pulse(input logic [127:0] data);
        mem_resp  = 1'b1;
        mem_rdata = data;
        @(negedge clk);
        mem_resp  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = '0; d_address = '0; i_wdata = '0; d_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_mem_read",  128'(mem_read),    128'(0));
        chk("rst_mem_write", 128'(mem_write),   128'(0));
        chk("rst_mem_addr",  128'(mem_address), 128'(0));
        chk("rst_mem_wdata", mem_wdata,         128'(0));
        chk("rst_resp",      128'({i_resp, d_resp}), 128'(0));
        chk("rst_rdata",     i_rdata | d_rdata, 128'(0));
        reset = 1'b0;
        @(negedge clk);

        // I read only
        i_read = 1'b1; i_address = 16'h1230;
        @(negedge clk);
        chk("t1_mem_read",  128'(mem_read),    128'(1));
        chk("t1_mem_write", 128'(mem_write),   128'(0));
        chk("t1_mem_addr",  128'(mem_address), 128'h1230);
        repeat (2) @(negedge clk);
        chk("t1_hold_read", 128'(mem_read),    128'(1));
        l2_pulse(LINE_A);
        i_read = 1'b0;
        chk("t1_i_resp",    128'(i_resp),      128'(1));
        chk("t1_i_rdata",   i_rdata,           LINE_A);
        chk("t1_d_resp",    128'(d_resp),      128'(0));
        chk("t1_read_drop", 128'(mem_read),    128'(0));
        @(negedge clk);
        chk("t1_i_pulse",   128'(i_resp),      128'(0));
        @(negedge clk);

        // Simultaneous after reset, FAIR=1: D first, then I after one IDLE cycle
        do_reset();
        d_read = 1'b1; d_address = 16'h4000;
        i_read = 1'b1; i_address = 16'h0100;
        @(negedge clk);
        chk("t2_first_addr", 128'(mem_address), 128'h4000);
        l2_pulse(LINE_B);
        d_read = 1'b0;
        chk("t2_d_resp",     128'(d_resp),      128'(1));
        chk("t2_i_wait",     128'(i_resp),      128'(0));
        @(negedge clk);
        chk("t2_idle_gap",   128'(mem_read),    128'(0));
        @(negedge clk);
        chk("t2_second_rd",  128'(mem_read),    128'(1));
        chk("t2_second_addr",128'(mem_address), 128'h0100);
        l2_pulse(LINE_A);
        i_read = 1'b0;
        chk("t2_i_resp",     128'(i_resp),      128'(1));
        chk("t2_i_rdata",    i_rdata,           LINE_A);
        repeat (2) @(negedge clk);

        // Repeated fresh ties: round-robin D,I,D,I and fixed priority D,D,D,D
        do_reset();
        for (int r = 0; r < 4; r++) begin
            logic exp_d;
            exp_d = ((r % 2) == 0);
            d_read = 1'b1; d_address = 16'h0D00;
            i_read = 1'b1; i_address = 16'h0A00;
            @(negedge clk);
            chk($sformatf("t3_rr_addr%0d", r), 128'(mem_address), exp_d ? 128'h0D00 : 128'h0A00);
            chk($sformatf("t3_fp_addr%0d", r), 128'(f_mem_address), 128'h0D00);
            l2_pulse(LINE_C);
            d_read = 1'b0; i_read = 1'b0;
            chk($sformatf("t3_rr_resp%0d", r), 128'({d_resp, i_resp}), exp_d ? 128'(2) : 128'(1));
            chk($sformatf("t3_fp_resp%0d", r), 128'({f_d_resp, f_i_resp}), 128'(2));
            repeat (2) @(negedge clk);
        end

        // D write, inputs changed mid-SERVE must not disturb mem_*
        d_write = 1'b1; d_address = 16'h2050; d_wdata = LINE_C;
        @(negedge clk);
        chk("t4_mem_write", 128'(mem_write),   128'(1));
        chk("t4_mem_read",  128'(mem_read),    128'(0));
        chk("t4_addr",      128'(mem_address), 128'h2050);
        chk("t4_wdata",     mem_wdata,         LINE_C);
        d_address = 16'hFFFF; d_wdata = LINE_5;
        @(negedge clk);
        chk("t4_addr_hold", 128'(mem_address), 128'h2050);
        chk("t4_wdata_hold",mem_wdata,         LINE_C);
        l2_pulse(LINE_B);
        d_write = 1'b0;
        chk("t4_d_resp",    128'(d_resp),      128'(1));
        chk("t4_i_resp",    128'(i_resp),      128'(0));
        chk("t4_wr_drop",   128'(mem_write),   128'(0));
        @(negedge clk);
        chk("t4_d_pulse",   128'(d_resp),      128'(0));
        @(negedge clk);

        // Reset mid-SERVE aborts with no resp; a following request is served normally
        i_read = 1'b1; i_address = 16'h3330;
        @(negedge clk);
        chk("t5_serving",   128'(mem_read),    128'(1));
        reset = 1'b1; i_read = 1'b0;
        @(negedge clk);
        chk("t5_rst_read",  128'(mem_read),    128'(0));
        chk("t5_rst_addr",  128'(mem_address), 128'(0));
        chk("t5_rst_rdata", i_rdata,           128'(0));
        reset = 1'b0;
        l2_pulse(LINE_A);
        chk("t5_no_resp",   128'({i_resp, d_resp}), 128'(0));
        i_read = 1'b1; i_address = 16'h7770;
        @(negedge clk);
        chk("t5_regrant",   128'(mem_read),    128'(1));
        chk("t5_regr_addr", 128'(mem_address), 128'h7770);
        i_read = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_drop_hold", 128'(mem_read),    128'(1));
        l2_pulse(LINE_B);
        chk("t5_i_resp",    128'(i_resp),      128'(1));
        chk("t5_i_rdata",   i_rdata,           LINE_B);
        repeat (2) @(negedge clk);

        // Spurious mem_resp in IDLE is ignored; read+write together is a write
        l2_pulse(LINE_5);
        chk("t6_spur_resp", 128'({i_resp, d_resp}), 128'(0));
        chk("t6_spur_rdata",i_rdata,           LINE_B);
        @(negedge clk);
        chk("t6_spur_idle", 128'({mem_read, mem_write}), 128'(0));
        i_read = 1'b1; i_write = 1'b1; i_address = 16'h5550; i_wdata = LINE_5;
        @(negedge clk);
        chk("t6_rw_write",  128'(mem_write),   128'(1));
        chk("t6_rw_read",   128'(mem_read),    128'(0));
        chk("t6_rw_wdata",  mem_wdata,         LINE_5);
        l2_pulse(LINE_A);
        i_read = 1'b0; i_write = 1'b0;
        chk("t6_i_resp",    128'(i_resp),      128'(1));
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
